// File: rtl/bitfusion_pkg.sv
// Shared types and helpers for the Bit-Fusion sequencer: legal precisions,
// controller state encoding and the precision legality check.
package bitfusion_pkg;

   localparam logic [3:0] W2 = 4'd2;
   localparam logic [3:0] W4 = 4'd4;
   localparam logic [3:0] W8 = 4'd8;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      DRAIN,
      OUTPUT,
      FIN
   } state_t;

   function automatic logic width_legal(input logic [3:0] w);
      return (w == W2) || (w == W4) || (w == W8);
   endfunction

endpackage

// File: rtl/bitfusion_addr_gen.sv
// Operand address generator: word index within the current output (input
// buffer address) and a running weight address across the whole layer.
module bitfusion_addr_gen #(
   parameter int AW = 10,
   parameter int KW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clear,
   input  logic          i_advance,
   input  logic [KW-1:0] i_k_words,
   output logic [AW-1:0] o_in_addr,
   output logic [AW-1:0] o_wt_addr,
   output logic          o_first,
   output logic          o_last
);

   logic [KW-1:0] r_k;
   logic [AW-1:0] r_wt_addr;

   // NOTE: state registers use non-blocking assignments and an asynchronous
   // reset so every flop updates from pre-edge values in the same time step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k       <= '0;
         r_wt_addr <= '0;
      end else if (i_clear) begin
         r_k       <= '0;
         r_wt_addr <= '0;
      end else if (i_advance) begin
         r_k       <= o_last ? '0 : r_k + KW'(1);
         r_wt_addr <= r_wt_addr + AW'(1);
      end
   end

   assign o_in_addr = AW'(r_k);
   assign o_wt_addr = r_wt_addr;
   assign o_first   = (r_k == '0);
   assign o_last    = (r_k == i_k_words - KW'(1));

endmodule

// File: rtl/bitfusion_seq_ctrl.sv
// Layer sequencer for one Bit-Fusion unit: validates and latches the layer
// config, streams operand reads, waits out the wrapper latency, hands off outputs.
module bitfusion_seq_ctrl
   import bitfusion_pkg::*;
#(
   parameter int AW     = 10,
   parameter int KW     = 8,
   parameter int NW     = 8,
   parameter int FU_LAT = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_start,
   input  logic [3:0]    cfg_in_width,
   input  logic [3:0]    cfg_weight_width,
   input  logic          cfg_s_in,
   input  logic          cfg_s_weight,
   input  logic [KW-1:0] cfg_k_words,
   input  logic [NW-1:0] cfg_n_out,
   output logic          busy,
   output logic          cfg_err,
   output logic          in_rd_en,
   output logic [AW-1:0] in_rd_addr,
   output logic          wt_rd_en,
   output logic [AW-1:0] wt_rd_addr,
   output logic [3:0]    fu_in_width,
   output logic [3:0]    fu_weight_width,
   output logic          fu_s_in,
   output logic          fu_s_weight,
   output logic          fu_valid,
   output logic          fu_psum_clr,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [NW-1:0] out_idx,
   output logic          done
);

   state_t        r_state;
   state_t        w_next;
   logic [3:0]    r_in_width;
   logic [3:0]    r_weight_width;
   logic          r_s_in;
   logic          r_s_weight;
   logic [KW-1:0] r_k_words;
   logic [NW-1:0] r_n_out;
   logic [NW-1:0] r_out_idx;
   logic [2:0]    r_drain_cnt;
   logic          r_cfg_err;
   logic          r_fu_valid;
   logic          r_psum_clr;

   logic w_cfg_ok;
   logic w_start_ok;
   logic w_start_bad;
   logic w_issue;
   logic w_first;
   logic w_last;
   logic w_last_out;

   assign w_cfg_ok    = width_legal(cfg_in_width) && width_legal(cfg_weight_width) &&
                        (cfg_k_words != '0) && (cfg_n_out != '0);
   assign w_start_ok  = cfg_start && (r_state == IDLE) && w_cfg_ok;
   assign w_start_bad = cfg_start && (r_state == IDLE) && !w_cfg_ok;
   assign w_issue     = (r_state == ISSUE);
   assign w_last_out  = (r_out_idx == r_n_out - NW'(1));

   bitfusion_addr_gen #(
      .AW (AW),
      .KW (KW)
   ) u_addr_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (w_start_ok),
      .i_advance (w_issue),
      .i_k_words (r_k_words),
      .o_in_addr (in_rd_addr),
      .o_wt_addr (wt_rd_addr),
      .o_first   (w_first),
      .o_last    (w_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // NOTE: w_next takes its default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_start_ok) w_next = ISSUE;
         ISSUE:   if (w_last) w_next = DRAIN;
         DRAIN:   if (r_drain_cnt == 3'(FU_LAT)) w_next = OUTPUT;
         OUTPUT:  if (out_ready) w_next = w_last_out ? FIN : ISSUE;
         FIN:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_width     <= '0;
         r_weight_width <= '0;
         r_s_in         <= 1'b0;
         r_s_weight     <= 1'b0;
         r_k_words      <= '0;
         r_n_out        <= '0;
      end else if (w_start_ok) begin
         r_in_width     <= cfg_in_width;
         r_weight_width <= cfg_weight_width;
         r_s_in         <= cfg_s_in;
         r_s_weight     <= cfg_s_weight;
         r_k_words      <= cfg_k_words;
         r_n_out        <= cfg_n_out;
      end
   end

   // Drain counts from the cycle after the last read, i.e. the last fu_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_drain_cnt <= '0;
         r_out_idx   <= '0;
         r_cfg_err   <= 1'b0;
         r_fu_valid  <= 1'b0;
         r_psum_clr  <= 1'b0;
      end else begin
         r_drain_cnt <= (r_state == DRAIN) ? r_drain_cnt + 3'd1 : 3'd0;
         r_cfg_err   <= w_start_bad;
         r_fu_valid  <= w_issue;
         r_psum_clr  <= w_issue && w_first;
         if (w_start_ok)
            r_out_idx <= '0;
         else if ((r_state == OUTPUT) && out_ready && !w_last_out)
            r_out_idx <= r_out_idx + NW'(1);
      end
   end

   assign busy            = (r_state == ISSUE) || (r_state == DRAIN) || (r_state == OUTPUT);
   assign cfg_err         = r_cfg_err;
   assign in_rd_en        = w_issue;
   assign wt_rd_en        = w_issue;
   assign fu_in_width     = r_in_width;
   assign fu_weight_width = r_weight_width;
   assign fu_s_in         = r_s_in;
   assign fu_s_weight     = r_s_weight;
   assign fu_valid        = r_fu_valid;
   assign fu_psum_clr     = r_psum_clr;
   assign out_valid       = (r_state == OUTPUT);
   assign out_idx         = r_out_idx;
   assign done            = (r_state == FIN);

endmodule

// File: tb/tb_bitfusion_seq_ctrl.sv
// Directed self-checking bench for bitfusion_seq_ctrl with hand-computed
// cycle-by-cycle expectations.
module tb_bitfusion_seq_ctrl;

   localparam int AW     = 10;
   localparam int KW     = 8;
   localparam int NW     = 8;
   localparam int FU_LAT = 2;

   logic          clk;
   logic          rst_n;
   logic          cfg_start;
   logic [3:0]    cfg_in_width;
   logic [3:0]    cfg_weight_width;
   logic          cfg_s_in;
   logic          cfg_s_weight;
   logic [KW-1:0] cfg_k_words;
   logic [NW-1:0] cfg_n_out;
   logic          busy;
   logic          cfg_err;
   logic          in_rd_en;
   logic [AW-1:0] in_rd_addr;
   logic          wt_rd_en;
   logic [AW-1:0] wt_rd_addr;
   logic [3:0]    fu_in_width;
   logic [3:0]    fu_weight_width;
   logic          fu_s_in;
   logic          fu_s_weight;
   logic          fu_valid;
   logic          fu_psum_clr;
   logic          out_valid;
   logic          out_ready;
   logic [NW-1:0] out_idx;
   logic          done;

   int n_checks = 0;
   int n_errors = 0;

   bitfusion_seq_ctrl #(
      .AW     (AW),
      .KW     (KW),
      .NW     (NW),
      .FU_LAT (FU_LAT)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cfg_start        (cfg_start),
      .cfg_in_width     (cfg_in_width),
      .cfg_weight_width (cfg_weight_width),
      .cfg_s_in         (cfg_s_in),
      .cfg_s_weight     (cfg_s_weight),
      .cfg_k_words      (cfg_k_words),
      .cfg_n_out        (cfg_n_out),
      .busy             (busy),
      .cfg_err          (cfg_err),
      .in_rd_en         (in_rd_en),
      .in_rd_addr       (in_rd_addr),
      .wt_rd_en         (wt_rd_en),
      .wt_rd_addr       (wt_rd_addr),
      .fu_in_width      (fu_in_width),
      .fu_weight_width  (fu_weight_width),
      .fu_s_in          (fu_s_in),
      .fu_s_weight      (fu_s_weight),
      .fu_valid         (fu_valid),
      .fu_psum_clr      (fu_psum_clr),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_idx          (out_idx),
      .done             (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out_valid(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (out_valid) break;
         step();
      end
      check(tag, out_valid, 1);
   endtask

   task automatic set_cfg(input logic [3:0] iw, input logic [3:0] ww, input logic si,
                          input logic sw, input logic [KW-1:0] k, input logic [NW-1:0] n);
      cfg_in_width     = iw;
      cfg_weight_width = ww;
      cfg_s_in         = si;
      cfg_s_weight     = sw;
      cfg_k_words      = k;
      cfg_n_out        = n;
   endtask

   // Expected per-cycle traces for the first layer, index = cycle after start edge.
   logic [0:16] exp_rd;
   logic [0:16] exp_fv;
   logic [0:16] exp_clr;
   logic [0:16] exp_ov;
   logic [0:16] exp_done;
   logic [0:16] exp_busy;

   initial begin
      rst_n     = 1'b0;
      cfg_start = 1'b0;
      out_ready = 1'b0;
      set_cfg(4'd0, 4'd0, 1'b0, 1'b0, '0, '0);
      #2;
      check("rst busy", busy, 0);
      check("rst in_rd_en", in_rd_en, 0);
      check("rst fu_in_width", fu_in_width, 0);
      check("rst out_valid", out_valid, 0);
      check("rst done", done, 0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // Layer 1: 8/8 signed, k=3, n=2, out_ready tied high.
      exp_rd   = 17'b0111_0000_1110_0000_0;
      exp_fv   = 17'b0011_1000_0111_0000_0;
      exp_clr  = 17'b0010_0000_0100_0000_0;
      exp_ov   = 17'b0000_0001_0000_0010_0;
      exp_done = 17'b0000_0000_0000_0001_0;
      exp_busy = 17'b0111_1111_1111_1110_0;
      out_ready = 1'b1;
      set_cfg(4'd8, 4'd8, 1'b1, 1'b1, 8'd3, 8'd2);
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         check($sformatf("L1 busy c%0d", c), busy, exp_busy[c]);
         check($sformatf("L1 in_rd_en c%0d", c), in_rd_en, exp_rd[c]);
         check($sformatf("L1 wt_rd_en c%0d", c), wt_rd_en, exp_rd[c]);
         check($sformatf("L1 fu_valid c%0d", c), fu_valid, exp_fv[c]);
         check($sformatf("L1 fu_psum_clr c%0d", c), fu_psum_clr, exp_clr[c]);
         check($sformatf("L1 out_valid c%0d", c), out_valid, exp_ov[c]);
         check($sformatf("L1 done c%0d", c), done, exp_done[c]);
         if (exp_rd[c]) begin
            check($sformatf("L1 in_rd_addr c%0d", c), in_rd_addr, (c < 8) ? c - 1 : c - 8);
            check($sformatf("L1 wt_rd_addr c%0d", c), wt_rd_addr, (c < 8) ? c - 1 : c - 5);
         end
         if (exp_ov[c])
            check($sformatf("L1 out_idx c%0d", c), out_idx, (c < 8) ? 0 : 1);
         if (exp_busy[c]) begin
            check($sformatf("L1 fu_in_width c%0d", c), fu_in_width, 8);
            check($sformatf("L1 fu_s_weight c%0d", c), fu_s_weight, 1);
         end
         step();
      end
      out_ready = 1'b0;

      // Rejected starts: illegal width, k_words=0, n_out=0.
      set_cfg(4'd3, 4'd8, 1'b0, 1'b0, 8'd2, 8'd1);
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      check("bad width cfg_err", cfg_err, 1);
      check("bad width busy", busy, 0);
      check("bad width in_rd_en", in_rd_en, 0);
      step();
      check("bad width cfg_err pulse", cfg_err, 0);
      check("bad width rd later", in_rd_en, 0);
      set_cfg(4'd4, 4'd4, 1'b0, 1'b0, 8'd0, 8'd1);
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      check("k0 cfg_err", cfg_err, 1);
      check("k0 busy", busy, 0);
      step();
      set_cfg(4'd4, 4'd4, 1'b0, 1'b0, 8'd2, 8'd0);
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      check("n0 cfg_err", cfg_err, 1);
      check("n0 busy", busy, 0);
      step();

      // Layer 2: k=1, n=3, consumer stalls 5 cycles on output 1.
      set_cfg(4'd2, 4'd4, 1'b0, 1'b1, 8'd1, 8'd3);
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      check("L2 busy c1", busy, 1);
      check("L2 fu_weight_width", fu_weight_width, 4);
      step();
      step();
      step();
      check("L2 out_valid c4", out_valid, 0);
      step();
      check("L2 out_valid c5", out_valid, 1);
      check("L2 out_idx 0", out_idx, 0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("L2 issue out1 rd", in_rd_en, 1);
      check("L2 issue out1 idx", out_idx, 1);
      check("L2 issue out1 wt", wt_rd_addr, 1);
      check("L2 issue out1 in", in_rd_addr, 0);
      wait_out_valid("L2 out1 timeout", 20);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("L2 stall out_valid %0d", i), out_valid, 1);
         check($sformatf("L2 stall out_idx %0d", i), out_idx, 1);
         check($sformatf("L2 stall rd_en %0d", i), in_rd_en, 0);
         if (i < 4) step();
      end
      out_ready = 1'b1;
      step();
      check("L2 issue out2 rd", in_rd_en, 1);
      check("L2 issue out2 idx", out_idx, 2);
      check("L2 issue out2 wt", wt_rd_addr, 2);
      wait_out_valid("L2 out2 timeout", 20);
      step();
      check("L2 done", done, 1);
      check("L2 fin busy", busy, 0);
      step();
      check("L2 done pulse", done, 0);
      out_ready = 1'b0;

      // Layer 3: start during ISSUE ignored, then reset during DRAIN.
      set_cfg(4'd4, 4'd2, 1'b0, 1'b0, 8'd4, 8'd1);
      cfg_start = 1'b1;
      step();
      set_cfg(4'd8, 4'd8, 1'b1, 1'b1, 8'd2, 8'd2);
      step();
      cfg_start = 1'b0;
      check("L3 ignore cfg_err", cfg_err, 0);
      check("L3 ignore fu_in_width", fu_in_width, 4);
      check("L3 ignore fu_weight_width", fu_weight_width, 2);
      check("L3 ignore in_rd_addr", in_rd_addr, 1);
      step();
      step();
      step();
      step();
      check("L3 drain rd_en", in_rd_en, 0);
      check("L3 drain busy", busy, 1);
      check("L3 drain out_valid", out_valid, 0);
      rst_n = 1'b0;
      #1;
      check("L3 rst busy", busy, 0);
      check("L3 rst fu_in_width", fu_in_width, 0);
      check("L3 rst fu_valid", fu_valid, 0);
      check("L3 rst wt_rd_addr", wt_rd_addr, 0);
      check("L3 rst out_valid", out_valid, 0);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         check($sformatf("L3 no done %0d", i), done, 0);
      end

      // Layer 4: fresh start after abort.
      set_cfg(4'd8, 4'd8, 1'b0, 1'b0, 8'd2, 8'd1);
      out_ready = 1'b1;
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      check("L4 wt_rd_addr c1", wt_rd_addr, 0);
      step();
      check("L4 wt_rd_addr c2", wt_rd_addr, 1);
      check("L4 in_rd_addr c2", in_rd_addr, 1);
      wait_out_valid("L4 out timeout", 20);
      step();
      check("L4 done", done, 1);
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
